// File: rtl/central_fuzz_seq.sv
// Fuzz campaign sequencer: sweeps ip_mask, triggers each IP, traces bus traffic and drains it on fuzz-ack.
// Optional macro FUZZ_TIMEOUT_EN bounds every wait and reports it on timeout_err.
module central_fuzz_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IP = 4,
  parameter logic [ADDR_WIDTH-1:0] IP_BASE = 32'h3000_0000,
  parameter logic [ADDR_WIDTH-1:0] IP_STRIDE = 32'h0000_1000,
  parameter logic [ADDR_WIDTH-1:0] TRAFFIC_START = 32'h2000_0000,
  parameter logic [ADDR_WIDTH-1:0] TRAFFIC_END = 32'h2000_003C,
  parameter int TRACE_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] TRIG_ACK_ADDR = 32'h1000_0000,
  parameter logic [DATA_WIDTH-1:0] TRIG_ACK_DATA = 32'h5A5A_0001,
  parameter logic [ADDR_WIDTH-1:0] FUZZ_ACK_ADDR = 32'h1000_0004,
  parameter logic [DATA_WIDTH-1:0] FUZZ_ACK_DATA = 32'h63A9_1243,
  parameter logic [ADDR_WIDTH-1:0] ANOM_IND_ADDR = 32'h1000_0008,
  parameter logic [DATA_WIDTH-1:0] ANOM_IND_DATA = 32'hDEAD_0001,
  parameter logic [ADDR_WIDTH-1:0] ANOM_DATA_ADDR = 32'h1000_000C,
  parameter logic [ADDR_WIDTH-1:0] TRACE_OUT_ADDR = 32'h4000_0000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [NUM_IP-1:0]     ip_mask,
  output logic                  busy,
  output logic                  done,
  output logic [(NUM_IP > 1 ? $clog2(NUM_IP) : 1)-1:0] cur_ip,
  output logic [7:0]            anomaly_cnt,
  output logic [DATA_WIDTH-1:0] corner_case_payload,
  output logic                  timeout_err,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_done,
  input  logic                  s_valid,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0] s_data
);
  localparam int IPW = (NUM_IP > 1) ? $clog2(NUM_IP) : 1;
  localparam int TPW = $clog2(TRACE_DEPTH);
  localparam int CW = TPW + 1;
  localparam logic [CW-1:0] DEPTH_FULL = CW'(TRACE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TRIG_WR   = 3'd1;
  localparam logic [2:0] S_ACK_RD    = 3'd2;
  localparam logic [2:0] S_MON_RD    = 3'd3;
  localparam logic [2:0] S_XMIT      = 3'd4;
  localparam logic [2:0] S_NEXT_IP   = 3'd5;
  localparam logic [2:0] S_ANOM_WAIT = 3'd6;

  logic [2:0]            state, resume_state;
  logic [1:0]            mode_q;
  logic [NUM_IP-1:0]     mask_q;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] trace_addr [TRACE_DEPTH];
  logic [DATA_WIDTH-1:0] trace_data [TRACE_DEPTH];
  logic [TPW-1:0]        wr_ptr, rd_idx;
  logic [CW-1:0]         count, xmit_idx;
  logic                  xmit_half, fuzz_ack_q, anom_pending;
  logic                  fuzz_ack_hit, anom_ind_hit, anom_now, start_ok, push, tmo_hit;
  logic [IPW:0]          first_pick, next_pick;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic [DATA_WIDTH-1:0] trig_data;

  // Returns {found, index} of the lowest set bit at or above 'from'.
  function automatic logic [IPW:0] find_set(input logic [NUM_IP-1:0] mask, input int from);
    find_set = '0;
    for (int i = NUM_IP - 1; i >= 0; i--)
      if (mask[i] && i >= from) find_set = {1'b1, IPW'(i)};
  endfunction

  assign fuzz_ack_hit = s_valid && (s_addr == FUZZ_ACK_ADDR) && (s_data == FUZZ_ACK_DATA) && (state != S_IDLE);
  assign anom_ind_hit = s_valid && (s_addr == ANOM_IND_ADDR) && (s_data == ANOM_IND_DATA)
                        && (state != S_IDLE) && (state != S_ANOM_WAIT);
  assign anom_now   = anom_pending || anom_ind_hit;
  assign start_ok   = (state == S_IDLE) && start && (mode != 2'd0) && (|ip_mask);
  assign first_pick = find_set(ip_mask, 0);
  assign next_pick  = find_set(mask_q, int'(cur_ip) + 1);
  assign trig_addr  = IP_BASE + ADDR_WIDTH'(cur_ip) * IP_STRIDE;
  assign trig_data  = DATA_WIDTH'({20'hA0000, 2'b00, mode_q, 2'b00, mode_q, 2'b00, mode_q});
  assign rd_idx     = wr_ptr - count[TPW-1:0] + xmit_idx[TPW-1:0];
  assign push       = (state == S_MON_RD) && m_req && m_done && !tmo_hit;

  always_ff @(posedge clk) begin
    if (push) begin
      trace_addr[wr_ptr] <= m_addr;
      trace_data[wr_ptr] <= m_rdata;
    end
  end

  // Transactions always finish before anomaly handling, so ANOM_WAIT is entered only with m_req low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;             resume_state <= S_IDLE;
      mode_q <= '0;                mask_q <= '0;
      cur_addr <= TRAFFIC_START;   wr_ptr <= '0;
      count <= '0;                 xmit_idx <= '0;
      xmit_half <= 1'b0;           fuzz_ack_q <= 1'b0;
      anom_pending <= 1'b0;        busy <= 1'b0;
      done <= 1'b0;                cur_ip <= '0;
      anomaly_cnt <= '0;           corner_case_payload <= '0;
      m_req <= 1'b0;               m_we <= 1'b0;
      m_addr <= '0;                m_wdata <= '0;
    end else begin
      done <= 1'b0;
      if (fuzz_ack_hit) fuzz_ack_q <= 1'b1;
      if (anom_ind_hit) anom_pending <= 1'b1;
      if (tmo_hit) begin
        m_req <= 1'b0;       m_we <= 1'b0;
        fuzz_ack_q <= 1'b0;  anom_pending <= 1'b0;
        count <= '0;         wr_ptr <= '0;
        xmit_idx <= '0;      xmit_half <= 1'b0;
        state <= S_NEXT_IP;
      end else if (state != S_IDLE && state != S_ANOM_WAIT && !m_req && anom_now) begin
        anom_pending <= 1'b0;
        resume_state <= state;
        state <= S_ANOM_WAIT;
      end else begin
        case (state)
          S_IDLE: if (start_ok) begin
            mode_q <= mode;        mask_q <= ip_mask;
            cur_ip <= first_pick[IPW-1:0];
            busy <= 1'b1;          anomaly_cnt <= '0;
            cur_addr <= TRAFFIC_START;
            state <= S_TRIG_WR;
          end
          S_TRIG_WR: if (!m_req) begin
            m_req <= 1'b1;  m_we <= 1'b1;
            m_addr <= trig_addr;  m_wdata <= trig_data;
          end else if (m_done) begin
            m_req <= 1'b0;  m_we <= 1'b0;
            state <= S_ACK_RD;
          end
          S_ACK_RD: if (!m_req) begin
            m_req <= 1'b1;  m_we <= 1'b0;
            m_addr <= TRIG_ACK_ADDR;
          end else if (m_done) begin
            m_req <= 1'b0;
            if (m_rdata == TRIG_ACK_DATA) state <= S_MON_RD;
          end
          S_MON_RD: if (!m_req) begin
            if (fuzz_ack_q) begin
              xmit_idx <= '0;  xmit_half <= 1'b0;
              state <= S_XMIT;
            end else begin
              m_req <= 1'b1;  m_we <= 1'b0;
              m_addr <= cur_addr;
            end
          end else if (m_done) begin
            m_req <= 1'b0;
            wr_ptr <= wr_ptr + 1'b1;
            if (count != DEPTH_FULL) count <= count + 1'b1;
            cur_addr <= (cur_addr >= TRAFFIC_END) ? TRAFFIC_START : cur_addr + STEP;
          end
          // Each trace entry drains as an address word followed by its data word.
          S_XMIT: if (!m_req) begin
            if (xmit_idx == count) begin
              count <= '0;  wr_ptr <= '0;
              fuzz_ack_q <= 1'b0;
              state <= S_NEXT_IP;
            end else begin
              m_req <= 1'b1;  m_we <= 1'b1;
              m_addr <= xmit_half ? TRACE_OUT_ADDR + STEP : TRACE_OUT_ADDR;
              m_wdata <= xmit_half ? trace_data[rd_idx] : DATA_WIDTH'(trace_addr[rd_idx]);
            end
          end else if (m_done) begin
            m_req <= 1'b0;  m_we <= 1'b0;
            xmit_half <= !xmit_half;
            if (xmit_half) xmit_idx <= xmit_idx + 1'b1;
          end
          S_NEXT_IP: if (next_pick[IPW]) begin
            cur_ip <= next_pick[IPW-1:0];
            cur_addr <= TRAFFIC_START;
            state <= S_TRIG_WR;
          end else begin
            busy <= 1'b0;  done <= 1'b1;
            state <= S_IDLE;
          end
          S_ANOM_WAIT: if (s_valid && s_addr == ANOM_DATA_ADDR) begin
            corner_case_payload <= s_data;
            if (anomaly_cnt != 8'hFF) anomaly_cnt <= anomaly_cnt + 1'b1;
            state <= resume_state;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef FUZZ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [2:0]    prev_state;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_wait;

  // Re-polls in ACK_RD keep the same state, so the budget spans the whole polling phase.
  assign tmo_wait = m_req || (state == S_ACK_RD) || (state == S_ANOM_WAIT);
  assign tmo_hit  = tmo_wait && (state == prev_state) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_state <= S_IDLE;
      tmo_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      prev_state <= state;
      if (!tmo_wait || state != prev_state || tmo_hit) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 1'b1;
      if (start_ok) timeout_err <= 1'b0;
      else if (tmo_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_central_fuzz_seq.sv
// Directed bench for central_fuzz_seq: a bus/slave responder model plus hand-computed expectations.
module tb_central_fuzz_seq;
  localparam logic [31:0] TRIG_ACK_ADDR  = 32'h1000_0000;
  localparam logic [31:0] TRIG_ACK_DATA  = 32'h5A5A_0001;
  localparam logic [31:0] FUZZ_ACK_ADDR  = 32'h1000_0004;
  localparam logic [31:0] FUZZ_ACK_DATA  = 32'h63A9_1243;
  localparam logic [31:0] ANOM_IND_ADDR  = 32'h1000_0008;
  localparam logic [31:0] ANOM_IND_DATA  = 32'hDEAD_0001;
  localparam logic [31:0] ANOM_DATA_ADDR = 32'h1000_000C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic [1:0]  mode;
  logic [3:0]  ip_mask;
  logic        busy, done, timeout_err;
  logic [1:0]  cur_ip;
  logic [7:0]  anomaly_cnt;
  logic [31:0] corner_case_payload;
  logic        m_req, m_we, m_done, s_valid;
  logic [31:0] m_addr, m_wdata, m_rdata, s_addr, s_data;

  int n_compared = 0;
  int n_mismatched = 0;
  int done_cnt = 0, ack_reads = 0, traffic_reads = 0, since_ack = 0;
  int fuzz_after = 3, resp_delay = 0, anom_at = 0, payload_cd = 0, hold = 0;
  bit ack_ok = 1'b1, seen = 1'b0;
  logic [31:0] wr_addr_q[$], wr_data_q[$], wr_ip_q[$];

  central_fuzz_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .ip_mask(ip_mask),
    .busy(busy), .done(done), .cur_ip(cur_ip), .anomaly_cnt(anomaly_cnt),
    .corner_case_payload(corner_case_payload), .timeout_err(timeout_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done),
    .s_valid(s_valid), .s_addr(s_addr), .s_data(s_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [3:0] mask);
    @(negedge clk);
    start = 1'b1; mode = m; ip_mask = mask;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sendSlave(input logic [31:0] a, input logic [31:0] d);
    s_valid = 1'b1; s_addr = a; s_data = d;
  endtask

  task automatic waitDone(input string tag, input int bound);
    int base = done_cnt;
    for (int i = 0; i < bound && done_cnt == base; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput(tag, 32'(done_cnt - base), 32'd1);
  endtask

  task automatic resetLog();
    wr_addr_q.delete(); wr_data_q.delete(); wr_ip_q.delete();
    ack_reads = 0; traffic_reads = 0; since_ack = 0;
  endtask

  function automatic bit is_traffic(input logic [31:0] a);
    return a >= 32'h2000_0000 && a <= 32'h2000_003C;
  endfunction

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  // Bus and slave-side responder: logs master writes, answers reads, injects fuzz-ack and anomaly traffic.
  initial begin
    m_done = 1'b0; m_rdata = '0; s_valid = 1'b0; s_addr = '0; s_data = '0;
    forever begin
      @(negedge clk);
      m_done = 1'b0; s_valid = 1'b0;
      if (payload_cd > 0) begin
        payload_cd--;
        if (payload_cd == 2) sendSlave(ANOM_IND_ADDR, ANOM_IND_DATA);
        else if (payload_cd == 0) sendSlave(ANOM_DATA_ADDR, 32'hCAFE_F00D);
      end
      if (!m_req) seen = 1'b0;
      else begin
        if (!seen) begin
          seen = 1'b1; hold = resp_delay;
          if (m_we) begin
            wr_addr_q.push_back(m_addr); wr_data_q.push_back(m_wdata); wr_ip_q.push_back(32'(cur_ip));
          end else if (m_addr == TRIG_ACK_ADDR) ack_reads++;
          else if (is_traffic(m_addr) && anom_at != 0 && traffic_reads + 1 == anom_at)
            sendSlave(ANOM_IND_ADDR, ANOM_IND_DATA);
        end
        if (hold == 0) begin
          m_done = 1'b1; seen = 1'b0;
          m_rdata = (m_addr == TRIG_ACK_ADDR) ? (ack_ok ? TRIG_ACK_DATA : 32'h0) : ~m_addr;
          if (!m_we && is_traffic(m_addr)) begin
            traffic_reads++; since_ack++;
            if (anom_at != 0 && traffic_reads == anom_at) payload_cd = 4;
            if (since_ack == fuzz_after) begin
              since_ack = 0;
              sendSlave(FUZZ_ACK_ADDR, FUZZ_ACK_DATA);
            end
          end
        end else hold--;
      end
    end
  end

  initial begin
    logic [31:0] a;
    int base;
    bit found;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; ip_mask = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_m_req", 32'(m_req), 32'd0);
    checkOutput("reset_anom_cnt", 32'(anomaly_cnt), 32'd0);
    checkOutput("reset_payload", corner_case_payload, 32'd0);
    checkOutput("reset_timeout", 32'(timeout_err), 32'd0);

    $display("[TB] illegal starts");
    applyStimulus(2'd0, 4'b0001);
    repeat (2) @(negedge clk);
    checkOutput("mode0_busy", 32'(busy), 32'd0);
    applyStimulus(2'd1, 4'b0000);
    repeat (2) @(negedge clk);
    checkOutput("mask0_busy", 32'(busy), 32'd0);
    checkOutput("illegal_no_writes", 32'(wr_addr_q.size()), 32'd0);

    $display("[TB] single IP, three reads");
    resetLog(); fuzz_after = 3;
    applyStimulus(2'd1, 4'b0001);
    waitDone("t1_done", 300);
    checkOutput("t1_nwrites", 32'(wr_addr_q.size()), 32'd7);
    checkOutput("t1_trig_addr", wr_addr_q[0], 32'h3000_0000);
    checkOutput("t1_trig_data", wr_data_q[0], 32'hA000_0111);
    checkOutput("t1_ack_polls", 32'(ack_reads), 32'd1);
    for (int j = 0; j < 3; j++) begin
      a = 32'h2000_0000 + 32'(4 * j);
      checkOutput($sformatf("t1_drain_aw%0d", j), wr_addr_q[1 + 2 * j], 32'h4000_0000);
      checkOutput($sformatf("t1_drain_a%0d", j), wr_data_q[1 + 2 * j], a);
      checkOutput($sformatf("t1_drain_dw%0d", j), wr_addr_q[2 + 2 * j], 32'h4000_0004);
      checkOutput($sformatf("t1_drain_d%0d", j), wr_data_q[2 + 2 * j], ~a);
    end
    checkOutput("t1_busy_after", 32'(busy), 32'd0);

    $display("[TB] mask sweep 1010");
    resetLog(); fuzz_after = 1;
    applyStimulus(2'd2, 4'b1010);
    repeat (4) @(negedge clk);
    applyStimulus(2'd1, 4'b0001);
    waitDone("t2_done", 400);
    checkOutput("t2_nwrites", 32'(wr_addr_q.size()), 32'd6);
    checkOutput("t2_trig0_addr", wr_addr_q[0], 32'h3000_1000);
    checkOutput("t2_trig0_data", wr_data_q[0], 32'hA000_0222);
    checkOutput("t2_trig0_ip", wr_ip_q[0], 32'd1);
    checkOutput("t2_trig1_addr", wr_addr_q[3], 32'h3000_3000);
    checkOutput("t2_trig1_data", wr_data_q[3], 32'hA000_0222);
    checkOutput("t2_trig1_ip", wr_ip_q[3], 32'd3);

    $display("[TB] trace wrap, 20 reads");
    resetLog(); fuzz_after = 20;
    applyStimulus(2'd3, 4'b0001);
    waitDone("t3_done", 600);
    checkOutput("t3_nwrites", 32'(wr_addr_q.size()), 32'd17);
    for (int j = 0; j < 8; j++) begin
      a = 32'h2000_0000 + 32'(4 * ((12 + j) % 16));
      checkOutput($sformatf("t3_entry_a%0d", j), wr_data_q[1 + 2 * j], a);
      checkOutput($sformatf("t3_entry_d%0d", j), wr_data_q[2 + 2 * j], ~a);
    end

    $display("[TB] anomaly during a read");
    resetLog(); fuzz_after = 4; anom_at = 2; resp_delay = 3;
    applyStimulus(2'd1, 4'b0001);
    waitDone("t4_done", 600);
    anom_at = 0; resp_delay = 0;
    checkOutput("t4_payload", corner_case_payload, 32'hCAFE_F00D);
    checkOutput("t4_anom_cnt", 32'(anomaly_cnt), 32'd1);
    checkOutput("t4_nwrites", 32'(wr_addr_q.size()), 32'd9);
    checkOutput("t4_entry1", wr_data_q[3], 32'h2000_0004);
    checkOutput("t4_entry2", wr_data_q[5], 32'h2000_0008);
    checkOutput("t4_entry3", wr_data_q[7], 32'h2000_000C);

`ifdef FUZZ_TIMEOUT_EN
    $display("[TB] trigger-ack timeout");
    resetLog(); fuzz_after = 1; ack_ok = 1'b0;
    applyStimulus(2'd2, 4'b0011);
    checkOutput("t5_cnt_cleared", 32'(anomaly_cnt), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      found = timeout_err;
    end
    ack_ok = 1'b1;
    checkOutput("t5_timeout_err", 32'(timeout_err), 32'd1);
    waitDone("t5_done", 400);
    checkOutput("t5_trig0", wr_addr_q[0], 32'h3000_0000);
    checkOutput("t5_trig1", wr_addr_q[1], 32'h3000_1000);
    checkOutput("t5_err_sticky", 32'(timeout_err), 32'd1);
`else
    $display("[TB] trigger-ack never returns, unbounded poll");
    resetLog(); fuzz_after = 1; ack_ok = 1'b0;
    applyStimulus(2'd2, 4'b0001);
    checkOutput("t5_cnt_cleared", 32'(anomaly_cnt), 32'd0);
    repeat (1200) @(negedge clk);
    checkOutput("t5_still_busy", 32'(busy), 32'd1);
    checkOutput("t5_no_timeout", 32'(timeout_err), 32'd0);
    checkOutput("t5_polling", 32'(ack_reads > 500), 32'd1);
    ack_ok = 1'b1;
    waitDone("t5_done", 400);
`endif

    $display("[TB] reset during drain");
    resetLog(); fuzz_after = 3;
    applyStimulus(2'd1, 4'b0001);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = m_req && m_we && (m_addr == 32'h4000_0000);
    end
    checkOutput("t6_in_xmit", 32'(found), 32'd1);
    base = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t6_m_req", 32'(m_req), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_m_addr", m_addr, 32'd0);
    checkOutput("t6_cur_ip", 32'(cur_ip), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t6_no_done", 32'(done_cnt - base), 32'd0);
    resetLog(); fuzz_after = 2;
    applyStimulus(2'd3, 4'b0100);
    waitDone("t6_restart_done", 300);
    checkOutput("t6_trig_addr", wr_addr_q[0], 32'h3000_2000);
    checkOutput("t6_trig_data", wr_data_q[0], 32'hA000_0333);
    checkOutput("t6_trig_ip", wr_ip_q[0], 32'd2);
    checkOutput("t6_first_entry", wr_data_q[1], 32'h2000_0000);
    checkOutput("t6_nwrites", 32'(wr_addr_q.size()), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
